// File: rtl/vga_scanout_pkg.sv
// Shared timing helpers and scan-out FSM encoding for the VGA scan-out engine.
package vga_scanout_pkg;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } scan_state_t;

    // Full line/frame length from the four timing segments.
    function automatic int unsigned total_len(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // First counter value inside the sync pulse.
    function automatic int unsigned sync_start(input int unsigned act, input int unsigned fp);
        return act + fp;
    endfunction

    // First counter value after the sync pulse.
    function automatic int unsigned sync_end(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync);
        return act + fp + sync;
    endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; the write-side ready flag is registered
// and held low during reset.
module vga_pixel_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             push_c;
    logic             pop_c;

    assign push_c    = wr_valid && wr_ready;
    assign pop_c     = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; a pop on a full FIFO does not reopen the write side early.
    always_comb begin
        count_nxt = count + CW'(push_c) - CW'(pop_c);
    end

    // Storage array; reset only flushes pointers, contents are don't-care.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nxt;
            wr_ready <= (count_nxt != CW'(DEPTH));
            empty    <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/vga_scanout_engine.sv
// VGA scan-out: free-running timing generator plus a frame-locking pixel drain from the FIFO.
module vga_scanout_engine
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic        HS_POL     = 1'b0,
    parameter logic        VS_POL     = 1'b0,
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3*COLOR_BITS-1:0] s_data,
    input  logic                    s_sof,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_de,
    output logic [COLOR_BITS-1:0]   vga_r,
    output logic [COLOR_BITS-1:0]   vga_g,
    output logic [COLOR_BITS-1:0]   vga_b,
    output logic                    frame_start,
    output logic                    underflow
);

    localparam int unsigned H_TOTAL  = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = sync_start(H_ACTIVE, H_FP);
    localparam int unsigned HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int unsigned VS_START = sync_start(V_ACTIVE, V_FP);
    localparam int unsigned VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned PW       = 3 * COLOR_BITS;
    localparam int unsigned FW       = PW + 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active_c;
    logic          origin_c;
    logic          hs_c;
    logic          vs_c;

    logic [FW-1:0] head_c;
    logic          head_sof_c;
    logic [PW-1:0] head_pix_c;
    logic          fifo_empty;

    scan_state_t   state;
    scan_state_t   state_nxt;
    logic          pop_c;
    logic [PW-1:0] pix_c;
    logic          fs_c;
    logic          err_c;

    assign active_c   = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign origin_c   = (h_cnt == '0) && (v_cnt == '0);
    assign hs_c       = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    assign vs_c       = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
    assign head_sof_c = head_c[FW-1];
    assign head_pix_c = head_c[PW-1:0];

    vga_pixel_fifo #(
        .WIDTH (FW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (s_valid),
        .wr_data   ({s_sof, s_data}),
        .wr_ready  (s_ready),
        .rd_en     (pop_c),
        .rd_data_c (head_c),
        .empty     (fifo_empty)
    );

    // Free-running raster counters; only reset restarts them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Lock FSM next-state: discard to a sof, wait for the raster origin, then one pop per active pixel.
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        pix_c     = '0;
        fs_c      = 1'b0;
        err_c     = 1'b0;
        case (state)
            ST_SEEK: begin
                if (!fifo_empty) begin
                    if (head_sof_c) begin
                        state_nxt = ST_ARMED;
                    end else begin
                        pop_c = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (origin_c && !fifo_empty) begin
                    pop_c     = 1'b1;
                    pix_c     = head_pix_c;
                    fs_c      = 1'b1;
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (active_c) begin
                    if (fifo_empty || (head_sof_c && !origin_c)) begin
                        err_c     = 1'b1;
                        state_nxt = ST_SEEK;
                    end else begin
                        pop_c = 1'b1;
                        pix_c = head_pix_c;
                        fs_c  = head_sof_c;
                    end
                end
            end
            default: state_nxt = ST_SEEK;
        endcase
    end

    // State and output registers; all pins lag the counters by one cycle together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                   <= ST_SEEK;
            vga_hs                  <= ~HS_POL;
            vga_vs                  <= ~VS_POL;
            vga_de                  <= 1'b0;
            {vga_r, vga_g, vga_b}   <= '0;
            frame_start             <= 1'b0;
            underflow               <= 1'b0;
        end else begin
            state                   <= state_nxt;
            vga_hs                  <= hs_c ? HS_POL : ~HS_POL;
            vga_vs                  <= vs_c ? VS_POL : ~VS_POL;
            vga_de                  <= active_c;
            {vga_r, vga_g, vga_b}   <= pix_c;
            frame_start             <= fs_c;
            if (err_c) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout_engine.sv
// Directed bench for the VGA scan-out engine in a small 14x7 raster mode.
module tb_vga_scanout_engine;

    localparam int unsigned CB    = 4;
    localparam int unsigned PW    = 3 * CB;
    localparam int          H_TOT = 14;
    localparam int          F_TOT = 98;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] s_data;
    logic          s_sof;
    logic          s_valid;
    logic          s_ready;
    logic          vga_hs;
    logic          vga_vs;
    logic          vga_de;
    logic [CB-1:0] vga_r;
    logic [CB-1:0] vga_g;
    logic [CB-1:0] vga_b;
    logic          frame_start;
    logic          underflow;

    int n_checks  = 0;
    int n_fail    = 0;
    int pos       = 0;
    int fr        = 0;
    bit started   = 1'b0;
    int ready_low = 0;

    logic [PW:0] src_q [$];
    logic [PW:0] sb_q  [$];

    vga_scanout_engine #(
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (2),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .HS_POL     (1'b0),
        .VS_POL     (1'b0),
        .COLOR_BITS (CB),
        .FIFO_AW    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (frame %0d pos %0d)", tag, got, exp, fr, pos);
        end
    endtask

    function automatic bit act();
        return ((pos % H_TOT) < 8) && ((pos / H_TOT) < 4);
    endfunction

    function automatic int pix();
        return (pos / H_TOT) * 8 + (pos % H_TOT);
    endfunction

    task automatic drive();
        if (src_q.size() > 0) begin
            s_valid = 1'b1;
            s_sof   = src_q[0][PW];
            s_data  = src_q[0][PW-1:0];
        end else begin
            s_valid = 1'b0;
            s_sof   = 1'b0;
            s_data  = '0;
        end
    endtask

    // One clock: retire an accepted word, advance the pin-position model, re-drive the source.
    task automatic tick();
        logic acc;
        logic rel;
        acc = s_valid && s_ready;
        rel = reset;
        if (s_valid && !s_ready && rel) ready_low++;
        @(posedge clk);
        #1;
        if (acc && rel) begin
            sb_q.push_back({s_sof, s_data});
            src_q.delete(0);
        end
        if (!rel) begin
            started = 1'b0;
        end else if (!started) begin
            started = 1'b1;
            pos     = 0;
            fr      = 0;
        end else begin
            pos++;
            if (pos == F_TOT) begin
                pos = 0;
                fr++;
            end
        end
        drive();
    endtask

    task automatic load_frame(input int base, input int n);
        for (int k = 0; k < n; k++) src_q.push_back({(k == 0), PW'(base + k)});
        drive();
    endtask

    task automatic load_junk(input int n);
        for (int j = 0; j < n; j++) src_q.push_back({1'b0, PW'(12'hF00 + j)});
        drive();
    endtask

    task automatic check_pins(input string tag, input logic [PW-1:0] exp_rgb,
                              input logic exp_fs, input logic exp_uf);
        int   ph;
        int   pv;
        logic hs_e;
        logic vs_e;
        logic de_e;
        ph   = pos % H_TOT;
        pv   = pos / H_TOT;
        hs_e = !((ph >= 10) && (ph < 12));
        vs_e = !(pv == 5);
        de_e = (ph < 8) && (pv < 4);
        chk({tag, ".hs"},  32'(vga_hs), 32'(hs_e));
        chk({tag, ".vs"},  32'(vga_vs), 32'(vs_e));
        chk({tag, ".de"},  32'(vga_de), 32'(de_e));
        chk({tag, ".rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        chk({tag, ".fs"},  32'(frame_start), 32'(exp_fs));
        chk({tag, ".uf"},  32'(underflow), 32'(exp_uf));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        src_q.delete();
        sb_q.delete();
        drive();
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst.hs",    32'(vga_hs), 32'd1);
            chk("rst.vs",    32'(vga_vs), 32'd1);
            chk("rst.de",    32'(vga_de), 32'd0);
            chk("rst.rgb",   32'({vga_r, vga_g, vga_b}), 32'd0);
            chk("rst.fs",    32'(frame_start), 32'd0);
            chk("rst.uf",    32'(underflow), 32'd0);
            chk("rst.ready", 32'(s_ready), 32'd0);
        end
        reset = 1'b1;
    endtask

    initial begin
        logic        uf;
        logic [PW:0] w;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;

        // 1: reset values, then idle raster timing over two lines
        do_reset(3);
        tick();
        chk("t1.ready", 32'(s_ready), 32'd1);
        check_pins("t1", '0, 1'b0, 1'b0);
        repeat (2 * H_TOT - 1) begin
            tick();
            check_pins("t1", '0, 1'b0, 1'b0);
        end

        // 2: three pre-filled frames; first raster frame is missed while arming
        do_reset(2);
        load_frame(0, 32);
        load_frame(0, 32);
        load_frame(0, 32);
        repeat (4 * F_TOT) begin
            tick();
            if (act() && fr >= 1 && fr <= 3) check_pins("t2", PW'(pix()), pix() == 0, 1'b0);
            else                             check_pins("t2", '0, 1'b0, 1'b0);
        end

        // 3: source stalls after pixel 5, later frame relocks
        do_reset(2);
        load_frame(0, 6);
        repeat (3 * F_TOT) begin
            tick();
            uf = (fr == 1 && pos >= 6) || fr >= 2;
            if (act() && fr == 1 && pix() < 6) check_pins("t3", PW'(pix()), pix() == 0, uf);
            else if (act() && fr == 2)         check_pins("t3", PW'(200 + pix()), pix() == 0, uf);
            else                               check_pins("t3", '0, 1'b0, uf);
            if (fr == 1 && pos == 8) load_frame(200, 32);
        end

        // 4: stream starts mid-frame with non-sof words
        do_reset(2);
        repeat (2 * F_TOT) begin
            tick();
            if (act() && fr == 1) check_pins("t4", PW'(pix()), pix() == 0, 1'b0);
            else                  check_pins("t4", '0, 1'b0, 1'b0);
            if (fr == 0 && pos == 20) begin
                load_junk(4);
                load_frame(0, 32);
            end
        end

        // 5: short frame, next sof arrives at pixel 20
        do_reset(2);
        load_frame(0, 20);
        load_frame(64, 32);
        repeat (3 * F_TOT) begin
            tick();
            uf = (fr == 1 && pos >= 32) || fr >= 2;
            if (act() && fr == 1 && pix() < 20) check_pins("t5", PW'(pix()), pix() == 0, uf);
            else if (act() && fr == 2)          check_pins("t5", PW'(64 + pix()), pix() == 0, uf);
            else                                check_pins("t5", '0, 1'b0, uf);
        end

        // 6: back-pressure against a full FIFO, scoreboard of accepted words, mid-frame reset
        do_reset(2);
        ready_low = 0;
        load_frame(0, 32);
        load_frame(32, 32);
        load_frame(64, 32);
        repeat (2 * F_TOT + 49) begin
            tick();
            if (act() && fr >= 1) begin
                chk("t6.sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                w = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                check_pins("t6", w[PW-1:0], w[PW], 1'b0);
            end else begin
                check_pins("t6", '0, 1'b0, 1'b0);
            end
        end
        chk("t6.ready_low", 32'(ready_low > 0), 32'd1);
        do_reset(2);
        load_frame(12'hA00, 32);
        repeat (2 * F_TOT) begin
            tick();
            if (act() && fr == 1) check_pins("t6r", PW'(12'hA00 + pix()), pix() == 0, 1'b0);
            else                  check_pins("t6r", '0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
